// File: rtl/prisel_pkg.sv
// prisel_pkg: shared FSM state type and one-hot decode helper for the selector arbiters.
package prisel_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_e;

    // OR of the indices of all set bits; exact for one-hot input, up to 64 ports.
    function automatic int onehot_to_idx(input logic [63:0] oh);
        int r;
        r = 0;
        for (int i = 0; i < 64; i++) if (oh[i]) r = r | i;
        return r;
    endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating priority encoder; first set req bit at or after ptr, wrapping.
module rr_pick #(
    parameter int NumPorts = 4,
    parameter int IdxW = $clog2(NumPorts)
) (
    input  logic [NumPorts-1:0] req,
    input  logic [IdxW-1:0]     ptr,
    output logic                found,
    output logic [IdxW-1:0]     idx,
    output logic [NumPorts-1:0] onehot
);
    logic [NumPorts-1:0] rot;
    logic [IdxW-1:0]     off;
    logic [IdxW:0]       sum;

    always_comb begin
        rot = NumPorts'({req, req} >> ptr);
        found = |rot;
        off = '0;
        for (int k = NumPorts - 1; k >= 0; k--) if (rot[k]) off = IdxW'(k);
        sum = {1'b0, ptr} + {1'b0, off};
        idx = IdxW'(sum >= (IdxW+1)'(NumPorts) ? sum - (IdxW+1)'(NumPorts) : sum);
        onehot = found ? {{(NumPorts-1){1'b0}}, 1'b1} << idx : '0;
    end
endmodule

// File: rtl/rr_prisel.sv
// rr_prisel: N-port arbitrating selector with valid/ready request issue and routed response.
// Define RR_PRISEL_FIXED_PRIO_EN for legacy fixed priority (lowest index wins, no rotation).
module rr_prisel
    import prisel_pkg::*;
#(
    parameter int NumPorts = 4,
    parameter type T = logic [7:0],
    parameter type O = logic [7:0],
    localparam int IdxW = $clog2(NumPorts)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [NumPorts-1:0] req,
    input  T                    ins [NumPorts],
    output logic [NumPorts-1:0] gnt,
    output logic                busy,
    output T                    sel_i,
    output logic                sel_valid,
    input  logic                sel_ready,
    input  O                    sel_o,
    input  logic                resp_valid,
    output logic                resp_ready,
    output O                    outs [NumPorts],
    output logic [NumPorts-1:0] outs_valid
);
    state_e              state;
    logic [IdxW-1:0]     ptr;
    logic [IdxW-1:0]     w;
    logic                found;
    logic [IdxW-1:0]     idx;
    logic [NumPorts-1:0] onehot;

    assign w = IdxW'(onehot_to_idx(64'(gnt)));

    rr_pick #(.NumPorts(NumPorts), .IdxW(IdxW)) u_pick (
        .req(req),
        .ptr(ptr),
        .found(found),
        .idx(idx),
        .onehot(onehot)
    );

`ifdef RR_PRISEL_FIXED_PRIO_EN
    assign ptr = '0;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr <= '0;
        else if (state == WAIT_RESP && resp_valid) ptr <= (w == IdxW'(NumPorts-1)) ? '0 : w + 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt <= '0;
            sel_i <= '0;
            sel_valid <= 1'b0;
            resp_ready <= 1'b0;
            busy <= 1'b0;
            outs <= '{default: '0};
            outs_valid <= '0;
        end else begin
            outs_valid <= '0;
            case (state)
                IDLE: if (enable && found) begin
                    gnt <= onehot;
                    sel_i <= ins[idx];
                    sel_valid <= 1'b1;
                    busy <= 1'b1;
                    state <= ISSUE;
                end
                ISSUE: if (sel_ready) begin
                    sel_valid <= 1'b0;
                    resp_ready <= 1'b1;
                    state <= WAIT_RESP;
                end
                WAIT_RESP: if (resp_valid) begin
                    outs[w] <= sel_o;
                    outs_valid <= gnt;
                    gnt <= '0;
                    resp_ready <= 1'b0;
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rr_prisel.sv
// tb_rr_prisel: directed and randomized checks of rr_prisel against a transaction-level model.
module tb_rr_prisel;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic [N-1:0] req = '0;
    logic [7:0]   ins [N];
    logic [N-1:0] gnt;
    logic         busy;
    logic [7:0]   sel_i;
    logic         sel_valid;
    logic         sel_ready = 1'b0;
    logic [7:0]   sel_o = '0;
    logic         resp_valid = 1'b0;
    logic         resp_ready;
    logic [7:0]   outs [N];
    logic [N-1:0] outs_valid;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    rr_prisel dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .ins(ins),
        .gnt(gnt), .busy(busy), .sel_i(sel_i), .sel_valid(sel_valid),
        .sel_ready(sel_ready), .sel_o(sel_o), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .outs(outs), .outs_valid(outs_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: phase 0 idle, 1 issuing, 2 awaiting response.
    int         m_ph, m_w, m_ptr, m_ov;
    logic [7:0] m_sel;
    logic [7:0] m_outs [N];

    function automatic int winner(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph = 0; m_w = 0; m_ptr = 0; m_ov = 0; m_sel = '0;
            for (int i = 0; i < N; i++) m_outs[i] = '0;
        end else begin
            m_ov = 0;
            if (m_ph == 0) begin
                if (enable && req != 0) begin
                    m_w = winner(req, m_ptr);
                    m_sel = ins[m_w];
                    m_ph = 1;
                end
            end else if (m_ph == 1) begin
                if (sel_ready) m_ph = 2;
            end else if (resp_valid) begin
                m_outs[m_w] = sel_o;
                m_ov = 1 << m_w;
                m_ph = 0;
`ifdef RR_PRISEL_FIXED_PRIO_EN
                m_ptr = 0;
`else
                m_ptr = (m_w + 1) % N;
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("gnt", gnt, m_ph != 0 ? 64'(1 << m_w) : 64'd0);
            chk("busy", busy, m_ph != 0);
            chk("sel_valid", sel_valid, m_ph == 1);
            chk("resp_ready", resp_ready, m_ph == 2);
            chk("sel_i", sel_i, m_sel);
            chk("outs_valid", outs_valid, 64'(m_ov));
            for (int i = 0; i < N; i++) chk($sformatf("outs[%0d]", i), outs[i], m_outs[i]);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic int idx_of(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return -1;
    endfunction

    task automatic do_txn(input logic [N-1:0] r, output int g);
        int n;
        req = r; enable = 1'b1; sel_ready = 1'b1; resp_valid = 1'b0;
        n = 0;
        do begin tick(); n++; end while (gnt == 0 && n < 20);
        chk("gnt_timeout", gnt != 0, 1);
        g = idx_of(gnt);
        n = 0;
        while (!resp_ready && n < 20) begin tick(); n++; end
        chk("resp_ready_timeout", resp_ready, 1);
        sel_o = 8'($urandom);
        resp_valid = 1'b1;
        tick();
        resp_valid = 1'b0;
    endtask

    initial begin
        int g;
        logic [7:0] s_sel;
        logic [N-1:0] s_gnt;
        for (int i = 0; i < N; i++) ins[i] = 8'(i);
        // reset with all requests high
        req = 4'b1111; enable = 1'b1;
        repeat (3) tick();
        chk_en = 1'b1;
        chk("rst_gnt", gnt, 0);
        chk("rst_sel_valid", sel_valid, 0);
        chk("rst_outs_valid", outs_valid, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1; req = '0;
        tick();

        // single port
        req = 4'b0100; ins[2] = 8'h5A; sel_ready = 1'b1;
        tick();
        chk("t2_gnt", gnt, 4'b0100);
        chk("t2_sel_i", sel_i, 8'h5A);
        chk("t2_sel_valid", sel_valid, 1);
        req = '0;
        tick();
        chk("t2_resp_ready", resp_ready, 1);
        sel_o = 8'hC3; resp_valid = 1'b1;
        tick();
        resp_valid = 1'b0;
        chk("t2_outs2", outs[2], 8'hC3);
        chk("t2_outs_valid", outs_valid, 4'b0100);
        tick();
        chk("t2_outs_valid_pulse", outs_valid, 0);

        // round-robin from a fresh reset (ptr back to 0)
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        for (int i = 0; i < 8; i++) begin
            do_txn(4'b1111, g);
`ifdef RR_PRISEL_FIXED_PRIO_EN
            chk($sformatf("t3_grant%0d", i), 64'(g), 0);
`else
            chk($sformatf("t3_grant%0d", i), 64'(g), 64'(i % N));
`endif
        end

        // wrap and skip
        do_txn(4'b1001, g);
        chk("t4_wrap", 64'(g), 0);
        do_txn(4'b1001, g);
`ifdef RR_PRISEL_FIXED_PRIO_EN
        chk("t4_skip", 64'(g), 0);
`else
        chk("t4_skip", 64'(g), 3);
`endif
        req = '0;
        tick();

        // backpressure with payload churn and stray responses
        sel_ready = 1'b0; req = 4'b0010; ins[1] = 8'h77;
        tick();
        s_sel = sel_i; s_gnt = gnt;
        chk("t5_gnt", gnt, 4'b0010);
        req = '0;
        for (int i = 0; i < 5; i++) begin
            ins[1] = 8'($urandom); resp_valid = i[0]; sel_o = 8'($urandom);
            tick();
            chk("t5_sel_valid", sel_valid, 1);
            chk("t5_sel_i", sel_i, s_sel);
            chk("t5_gnt_hold", gnt, s_gnt);
        end
        resp_valid = 1'b0; sel_ready = 1'b1;
        tick();
        resp_valid = 1'b1; sel_o = 8'h3C;
        tick();
        resp_valid = 1'b0;
        chk("t5_outs1", outs[1], 8'h3C);

        // async reset while awaiting response
        req = 4'b0100;
        tick(); req = '0;
        tick();
        chk("t6_in_wait", resp_ready, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_gnt", gnt, 0);
        chk("t6_async_busy", busy, 0);
        tick();
        rst_n = 1'b1; resp_valid = 1'b1; sel_o = 8'hEE;
        tick();
        resp_valid = 1'b0;
        chk("t6_no_outs_valid", outs_valid, 0);
        do_txn(4'b1111, g);
        chk("t6_restart", 64'(g), 0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            req = 4'($urandom);
            for (int i = 0; i < N; i++) ins[i] = 8'($urandom);
            enable = ($urandom_range(0, 9) != 0);
            sel_ready = $urandom_range(0, 1) == 1;
            resp_valid = $urandom_range(0, 2) != 0;
            sel_o = 8'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
